matvec_requant: RTL and testbench
=================================

MATVEC_REQUANT -- requirements
Module: matvec_requant

Interface
REQ-001 The block SHALL have parameter K, default 8, giving the number of outputs per matrix-vector product.
REQ-002 The block SHALL have parameter IN_W, default 28, giving the signed input width.
REQ-003 The block SHALL have parameter OUT_W, default 14, giving the signed output width.
REQ-004 The block SHALL have parameter SHIFT, default 7, giving the arithmetic right-shift amount.
REQ-005 The block SHALL have parameter DEPTH, default 4, giving the output FIFO depth, a power of 2 that is at least 2.
REQ-006 clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 reset, input, 1, asynchronous, active-low reset.
REQ-008 in_valid, input, 1, upstream data valid; connects to the matvec output_valid.
REQ-009 in_ready, output, 1, block can accept; connects to the matvec output_ready.
REQ-010 in_data, input, IN_W, signed matvec result.
REQ-011 out_valid, output, 1, FIFO head valid.
REQ-012 out_ready, input, 1, downstream accept.
REQ-013 out_data, output, OUT_W, signed requantized value.
REQ-014 out_last, output, 1, asserted with the element for row K-1 of a product.
REQ-015 sat_count, output, 16, number of clamped elements since reset.

Function
REQ-016 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (count < DEPTH), driven from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 Requantization of an accepted word SHALL be in_data >>> SHIFT (arithmetic shift, floor rounding), then clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (default [-8192, 8191]).
REQ-020 The requantized value and its last flag SHALL be written into the FIFO on the accepting edge, so out_valid rises one cycle after the first accept into an empty FIFO (latency 1).
REQ-021 A row counter SHALL increment on each input transfer, wrapping from K-1 to 0; the FIFO entry's last flag SHALL be (row == K-1).
REQ-022 A simultaneous push and pop SHALL leave count unchanged; when full, a pop SHALL NOT enable a push in the same cycle.
REQ-023 Pointers SHALL wrap modulo DEPTH; output order SHALL equal input order.
REQ-024 sat_count SHALL increment on each input transfer whose value was clamped, and SHALL saturate at 65535.
REQ-025 out_data and out_last SHALL hold steady while out_valid=1 and out_ready=0.
REQ-026 Values presented while in_valid=0 (including X) SHALL NOT affect state.

Reset
REQ-027 Asserting reset SHALL immediately clear count, FIFO pointers, the row counter and sat_count; out_valid=0 and in_ready=0 while reset is asserted, and in_ready=1 afterwards.
REQ-028 out_data and out_last SHALL read 0 during reset, and contents in flight at reset SHALL be discarded.
REQ-029 Reset asserted mid-product SHALL restart the row counter at 0, so the next accepted word is row 0.

Configuration
REQ-030 With macro MATVEC_REQUANT_RELU_EN defined, a negative shifted value SHALL be replaced by 0 before clamping and SHALL NOT count as saturated; without it, signed values SHALL pass through the clamp unchanged.

Structure
REQ-031 A shared package matvec_pkg SHALL hold K, the IN_W/OUT_W widths, the SAT_MAX/SAT_MIN constants and the typedefs in_word_t and out_word_t.
REQ-032 The FIFO SHALL be a sub-module, matvec_fifo (parameterised width/depth, count-based full/empty), instantiated once with width OUT_W+1.

Verification
REQ-033 Scenario: in_data=1280, out_ready=1 -> out_data=10 one cycle after accept; sat_count=0.
REQ-034 Scenario: in_data=134217727 -> out_data=8191, sat_count=1; in_data=-134217728 -> -8192 without MATVEC_REQUANT_RELU_EN, or 0 with it (sat_count unchanged).
REQ-035 Scenario: in_data=-1280 -> out_data=-10 without the macro, 0 with it; in_data=-1 -> -1 without the macro (floor), 0 with it.
REQ-036 Scenario: out_ready=0 with 5 words offered -> in_ready drops after the 4th accept and the 5th is held; on out_ready=1, outputs emerge in order with nothing lost.
REQ-037 Scenario: 16 words streamed with random valid/ready -> out_last=1 on exactly the 8th and 16th outputs.
REQ-038 Scenario: reset asserted after 3 words of a product -> outputs empty; of the next 8 words, out_last=1 on the 8th.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared constants and word types for the matvec requantizer.
// Defaults here seed the parameters of matvec_requant.
package matvec_pkg;

    localparam int unsigned K     = 8;
    localparam int unsigned IN_W  = 28;
    localparam int unsigned OUT_W = 14;

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef logic signed [IN_W-1:0]  in_word_t;
    typedef logic signed [OUT_W-1:0] out_word_t;

endpackage

// File: rtl/matvec_fifo.sv
// Count-based synchronous FIFO; head is exposed directly, zero while empty.
module matvec_fifo #(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == CNT_W'(0));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/matvec_requant.sv
// Requantizes signed matvec results (shift + clamp), tags the last row of each
// product and buffers them in a small FIFO. Option: MATVEC_REQUANT_RELU_EN.
module matvec_requant #(
    parameter int unsigned K     = matvec_pkg::K,
    parameter int unsigned IN_W  = matvec_pkg::IN_W,
    parameter int unsigned OUT_W = matvec_pkg::OUT_W,
    parameter int unsigned SHIFT = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic [15:0]             sat_count
);

    import matvec_pkg::*;

    localparam int unsigned ROW_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned ENT_W = OUT_W + 1;
    localparam logic signed [IN_W-1:0] HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] LO = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0]  shifted_c;
    logic signed [OUT_W-1:0] quant_c;
    logic                    sat_c;
    logic                    last_c;
    logic                    push;
    logic                    full;
    logic                    empty;
    logic [ENT_W-1:0]        head;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [15:0]             sat_cnt_q, sat_cnt_d;

    assign shifted_c = in_data >>> SHIFT;
    assign last_c    = (row_q == ROW_W'(K - 1));
    // Ready is held low while reset is asserted and never looks at out_ready.
    assign in_ready  = reset && !full;
    assign push      = in_valid && in_ready;

    always_comb begin
        sat_c   = 1'b0;
        quant_c = shifted_c[OUT_W-1:0];
`ifdef MATVEC_REQUANT_RELU_EN
        if (shifted_c < 0) begin
            quant_c = '0;
        end else if (shifted_c > HI) begin
            quant_c = HI[OUT_W-1:0];
            sat_c   = 1'b1;
        end
`else
        if (shifted_c > HI) begin
            quant_c = HI[OUT_W-1:0];
            sat_c   = 1'b1;
        end else if (shifted_c < LO) begin
            quant_c = LO[OUT_W-1:0];
            sat_c   = 1'b1;
        end
`endif
    end

    always_comb begin
        row_d     = row_q;
        sat_cnt_d = sat_cnt_q;
        if (push) begin
            row_d = last_c ? '0 : row_q + ROW_W'(1);
            if (sat_c && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            row_q     <= row_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    matvec_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({last_c, quant_c}),
        .pop   (out_valid && out_ready),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_data  = head[OUT_W-1:0];
    assign out_last  = head[OUT_W];
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_matvec_requant.sv
// Directed bench for matvec_requant: requant values, backpressure, row tagging, reset.
module tb_matvec_requant;

    localparam int unsigned IN_W  = 28;
    localparam int unsigned OUT_W = 14;
`ifdef MATVEC_REQUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_last;
    logic [15:0]             sat_count;

    int total = 0;
    int bad   = 0;

    matvec_requant dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one word for exactly one cycle; returns at the negedge after the accept edge.
    task automatic send1(input logic signed [IN_W-1:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic pend;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b1;
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sat_count", sat_count, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Product 0: rows 0..7 with out_ready=1
        send1(28'sd1280);
        chk("r0_valid", out_valid, 1);
        chk("r0_data", out_data, 10);
        chk("r0_last", out_last, 0);
        chk("r0_sat", sat_count, 0);
        send1(28'sd134217727);
        chk("r1_data", out_data, 8191);
        chk("r1_sat", sat_count, 1);
        send1(-28'sd134217728);
        chk("r2_data", out_data, RELU ? 0 : -8192);
        chk("r2_sat", sat_count, RELU ? 1 : 2);
        send1(-28'sd1280);
        chk("r3_data", out_data, RELU ? 0 : -10);
        send1(-28'sd1);
        chk("r4_data", out_data, RELU ? 0 : -1);
        send1(28'sd1048575);
        chk("r5_data_nosat", out_data, 8191);
        chk("r5_sat", sat_count, RELU ? 1 : 2);
        send1(-28'sd129);
        chk("r6_data_floor", out_data, RELU ? 0 : -2);
        chk("r6_last", out_last, 0);
        send1(28'sd1048576);
        chk("r7_data", out_data, 8191);
        chk("r7_last", out_last, 1);
        chk("r7_sat", sat_count, RELU ? 2 : 3);
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_sat_hold", sat_count, RELU ? 2 : 3);

        // Backpressure: 5 words offered, only 4 fit
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'((i + 1) * 128);
            chk("bp_ready", in_ready, 1);
            @(negedge clk);
        end
        in_data = IN_W'(5 * 128);
        chk("bp_full_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_held_ready", in_ready, 0);
        chk("bp_held_data", out_data, 1);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_data", out_data, j + 1);
            chk("bp_drain_last", out_last, 0);
            pend = in_valid && in_ready;
            @(negedge clk);
            if (pend) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
        end
        chk("bp_empty", out_valid, 0);

        // Reset mid-product with words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send1(28'sd256);
        end
        chk("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_sat", sat_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // Random valid/ready stream of 16 words: last on 8th and 16th
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sent < 16 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = IN_W'((sent + 1) * 128);
            end else begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("stream_data", out_data, rcvd + 1);
                chk("stream_last", out_last, (rcvd % 8) == 7);
                rcvd++;
            end
        end
        in_valid = 1'b0;
        chk("stream_count", rcvd, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
